score_argmax: RTL and testbench

Reads the 10 class scores that the final fully-connected layer has written to temp score memory (addresses 0..9, signed 32-bit). Finds the index of the largest score and reports it as the recognised digit.

---
 rtl/nn_pkg.sv | 18 +
 rtl/max_tracker.sv | 41 ++++
 rtl/score_argmax.sv | 127 ++++++++++++
 tb/tb_score_argmax.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the classifier back end.
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 32;
  localparam int TEMP_ADDR_W = 14;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } argmax_state_t;

  typedef logic signed [DATA_W-1:0] score_t;

endpackage

// File: rtl/max_tracker.sv
// Running maximum of a stream of signed scores with their indices.
// best_idx/best_val already include the score presented this cycle, so a
// caller can latch the final result in the same cycle the last score arrives.
module max_tracker #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     init,
  input  logic                     valid,
  input  logic [IDX_W-1:0]         index,
  input  logic signed [DATA_W-1:0] value,
  output logic [IDX_W-1:0]         best_idx,
  output logic signed [DATA_W-1:0] best_val
);

  logic [IDX_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] val_q;
  logic                     take;

  // First score loads unconditionally; later ones only on strictly greater,
  // so the lowest index wins a tie.
  always_comb begin
    take     = valid && (init || (value > val_q));
    best_idx = take ? index : idx_q;
    best_val = take ? value : val_q;
  end

  // Best-so-far registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q <= '0;
      val_q <= '0;
    end else begin
      idx_q <= best_idx;
      val_q <= best_val;
    end
  end

endmodule

// File: rtl/score_argmax.sv
// Scans the class scores in temp memory and reports the argmax as the digit.
//
// state  | meaning
// IDLE   | waiting for a rising start
// ISSUE  | driving read addresses 0..NUM_CLASSES-1
// DRAIN  | addresses done, waiting for the last read to return
// FINISH | result latched, done high for this cycle
module score_argmax #(
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int ADDR_W      = nn_pkg::TEMP_ADDR_W,
  parameter int RD_LAT      = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic signed [DATA_W-1:0]    temp_q,
  output logic [ADDR_W-1:0]           temp_addr,
  output logic                        temp_rden,
  output logic                        busy,
  output logic                        done,
  output logic [nn_pkg::IDX_W-1:0]    digit,
  output logic signed [DATA_W-1:0]    max_score
);

  import nn_pkg::*;

  localparam int CNT_W = $clog2(NUM_CLASSES + 1);

  argmax_state_t            state;
  logic [CNT_W-1:0]         cnt;
  logic                     start_q;
  logic [RD_LAT-1:0]        vld_pipe;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_pipe;
  logic                     rd_vld;
  logic [IDX_W-1:0]         rd_idx;
  logic                     last_rd;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best_val;

  assign rd_vld  = vld_pipe[RD_LAT-1];
  assign rd_idx  = idx_pipe[RD_LAT-1];
  assign last_rd = rd_vld && (rd_idx == IDX_W'(NUM_CLASSES - 1));

  // Delay line tagging each issued address so temp_q is consumed on arrival.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= temp_rden;
      idx_pipe[0] <= temp_addr[IDX_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  max_tracker #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_tracker (
    .Clk      (Clk),
    .Reset    (Reset),
    .init     (rd_idx == '0),
    .valid    (rd_vld),
    .index    (rd_idx),
    .value    (temp_q),
    .best_idx (best_idx),
    .best_val (best_val)
  );

  // Sequencer. start is qualified by its rising edge so a held start runs
  // one scan only. Address 0 goes out on accept, so the counter starts at 1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      start_q   <= 1'b0;
      temp_addr <= '0;
      temp_rden <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digit     <= '0;
      max_score <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (start && !start_q) begin
            state     <= ST_ISSUE;
            cnt       <= CNT_W'(1);
            temp_addr <= '0;
            temp_rden <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (cnt == CNT_W'(NUM_CLASSES)) begin
            state     <= ST_DRAIN;
            temp_addr <= '0;
            temp_rden <= 1'b0;
          end else begin
            temp_addr <= ADDR_W'(cnt);
            cnt       <= cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (last_rd) begin
            state     <= ST_FINISH;
            done      <= 1'b1;
            digit     <= best_idx;
            max_score <= best_val;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_argmax.sv
// Scoreboard bench: one instance with RD_LAT=1 and one with RD_LAT=2 run the
// same scans; a monitor checks each done pulse against queued expectations.
module tb_score_argmax;
  import nn_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;

  score_t mem [NUM_CLASSES];

  logic [TEMP_ADDR_W-1:0] addr_a, addr_b;
  logic rden_a, rden_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] digit_a, digit_b;
  score_t max_a, max_b;
  score_t q_a = '0, q_b = '0, q_b1 = '0;

  typedef struct {
    logic [3:0] d;
    score_t     m;
  } exp_t;
  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  int cyc = 0;
  int e0 = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int exp_addr_a = 0, exp_addr_b = 0;
  int rden_cnt_a = 0, rden_cnt_b = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  score_argmax #(.RD_LAT(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .start(start), .temp_q(q_a),
    .temp_addr(addr_a), .temp_rden(rden_a), .busy(busy_a), .done(done_a),
    .digit(digit_a), .max_score(max_a)
  );

  score_argmax #(.RD_LAT(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .start(start), .temp_q(q_b),
    .temp_addr(addr_b), .temp_rden(rden_b), .busy(busy_b), .done(done_b),
    .digit(digit_b), .max_score(max_b)
  );

  function automatic score_t rd(input logic [TEMP_ADDR_W-1:0] a);
    if (int'(a) < NUM_CLASSES) return mem[int'(a)];
    return '0;
  endfunction

  // RAM models: one-cycle and two-cycle read latency
  always @(posedge Clk) if (rden_a) q_a <= rd(addr_a);
  always @(posedge Clk) begin
    q_b1 <= rd(addr_b);
    q_b  <= q_b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string t);
    chk({t, "_addr_a"},  64'(addr_a),  0);
    chk({t, "_rden_a"},  64'(rden_a),  0);
    chk({t, "_busy_a"},  64'(busy_a),  0);
    chk({t, "_done_a"},  64'(done_a),  0);
    chk({t, "_digit_a"}, 64'(digit_a), 0);
    chk({t, "_max_a"},   64'(max_a),   0);
    chk({t, "_addr_b"},  64'(addr_b),  0);
    chk({t, "_rden_b"},  64'(rden_b),  0);
    chk({t, "_busy_b"},  64'(busy_b),  0);
    chk({t, "_done_b"},  64'(done_b),  0);
    chk({t, "_digit_b"}, 64'(digit_b), 0);
    chk({t, "_max_b"},   64'(max_b),   0);
  endtask

  // Monitor: pops expectations on done, checks latency, busy and addresses.
  bit pd_a = 0, pd_b = 0;
  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (pd_a) chk("busy_a_after_done", 64'(busy_a), 0);
    if (pd_b) chk("busy_b_after_done", 64'(busy_b), 0);
    pd_a = done_a;
    pd_b = done_b;
    if (rden_a) begin
      chk("addr_seq_a", 64'(addr_a), 64'(exp_addr_a));
      exp_addr_a++;
      rden_cnt_a++;
    end
    if (rden_b) begin
      chk("addr_seq_b", 64'(addr_b), 64'(exp_addr_b));
      exp_addr_b++;
      rden_cnt_b++;
    end
    if (done_a) begin
      done_cnt_a++;
      chk("busy_a_with_done", 64'(busy_a), 1);
      if (exp_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_a actual=1 required=0");
      end else begin
        e = exp_q_a.pop_front();
        chk("digit_a", 64'(digit_a), 64'(e.d));
        chk("max_a", 64'(max_a), 64'(e.m));
        chk("latency_a", 64'(cyc - e0 + 1), 12);
      end
    end
    if (done_b) begin
      done_cnt_b++;
      chk("busy_b_with_done", 64'(busy_b), 1);
      if (exp_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_b actual=1 required=0");
      end else begin
        e = exp_q_b.pop_front();
        chk("digit_b", 64'(digit_b), 64'(e.d));
        chk("max_b", 64'(max_b), 64'(e.m));
        chk("latency_b", 64'(cyc - e0 + 1), 13);
      end
    end
  end

  task automatic begin_start(input bit expect_done, input logic [3:0] d, input score_t m);
    @(negedge Clk);
    start = 1'b1;
    exp_addr_a = 0; exp_addr_b = 0;
    rden_cnt_a = 0; rden_cnt_b = 0;
    if (expect_done) begin
      exp_q_a.push_back(exp_t'{d, m});
      exp_q_b.push_back(exp_t'{d, m});
    end
    @(negedge Clk);
    e0 = cyc;
  endtask

  task automatic pulse_start(input bit expect_done, input logic [3:0] d, input score_t m);
    begin_start(expect_done, d, m);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string t);
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0 && !busy_a && !busy_b) break;
    end
    chk({t, "_scan_completes"}, 64'(exp_q_a.size() + exp_q_b.size()), 0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int c0a, c0b;
    repeat (2) @(negedge Clk);
    check_zero("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // mixed scores, max in the middle
    mem = '{5, -3, 100, 7, 0, 1, 2, 3, 4, 6};
    pulse_start(1, 4'd2, 100);
    wait_drain("t1");
    chk("t1_rden_cycles_a", 64'(rden_cnt_a), 10);

    // all negative: signed compare
    mem = '{-50, -10, -20, -30, -40, -60, -70, -80, -90, -11};
    pulse_start(1, 4'd1, -10);
    wait_drain("t2");

    // tie: lowest index wins
    mem = '{0, 0, 0, 42, 0, 0, 0, 0, 42, 0};
    pulse_start(1, 4'd3, 42);
    wait_drain("t3");

    // full-range extremes
    mem = '{32'sh80000000, -1, -1, -1, -1, -1, -1, -1, -1, 32'sh7FFFFFFF};
    pulse_start(1, 4'd9, 32'sh7FFFFFFF);
    wait_drain("t4");
    chk("t4_rden_cycles_a", 64'(rden_cnt_a), 10);
    chk("t4_rden_cycles_b", 64'(rden_cnt_b), 10);
    chk("t4_last_addr_a", 64'(exp_addr_a), 10);

    // reset in the middle of cycle 5 of a scan
    mem = '{5, -3, 100, 7, 0, 1, 2, 3, 4, 6};
    c0a = done_cnt_a; c0b = done_cnt_b;
    pulse_start(0, 4'd0, 0);
    repeat (3) @(negedge Clk);
    chk("t5_digit_held_a", 64'(digit_a), 9);
    chk("t5_busy_mid_a", 64'(busy_a), 1);
    #1 Reset = 1'b1;
    #1 check_zero("t5");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    chk("t5_no_done_a", 64'(done_cnt_a - c0a), 0);
    chk("t5_no_done_b", 64'(done_cnt_b - c0b), 0);
    mem = '{0, 0, 0, 42, 0, 0, 0, 0, 42, 0};
    pulse_start(1, 4'd3, 42);
    wait_drain("t5b");

    // start held high for 20 cycles: one scan only
    mem = '{5, -3, 100, 7, 0, 1, 2, 3, 4, 6};
    c0a = done_cnt_a; c0b = done_cnt_b;
    begin_start(1, 4'd2, 100);
    repeat (19) @(negedge Clk);
    start = 1'b0;
    repeat (30) @(negedge Clk);
    chk("t6_one_done_a", 64'(done_cnt_a - c0a), 1);
    chk("t6_one_done_b", 64'(done_cnt_b - c0b), 1);
    chk("t6_queue_empty", 64'(exp_q_a.size() + exp_q_b.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
